// File: rtl/button_event_scheduler.sv
// Button event scheduler: per-button edge detect with hold-to-repeat timing,
// round-robin arbitration of pending events onto one valid/ready output.
module button_event_scheduler #(
   parameter int unsigned NUM_BTN   = 4,
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned HOLD_MS   = 500,
   parameter int unsigned REPEAT_MS = 100
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_BTN-1:0]         btn_level,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(NUM_BTN)-1:0] evt_id,
   output logic                       evt_repeat,
   output logic                       overrun
);

   localparam int unsigned ID_W       = $clog2(NUM_BTN);
   localparam int unsigned IDX_W      = ID_W + 1;
   localparam int unsigned HOLD_CYC   = CLK_FREQ / 1000 * HOLD_MS;
   localparam int unsigned REPEAT_CYC = CLK_FREQ / 1000 * REPEAT_MS;
   localparam int unsigned MAX_CYC    = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_RPT  = 2'd2;

   logic [1:0]       state_q [NUM_BTN];
   logic [1:0]       state_d [NUM_BTN];
   logic [CNT_W-1:0] cnt_q   [NUM_BTN];
   logic [CNT_W-1:0] cnt_d   [NUM_BTN];

   logic [NUM_BTN-1:0] prev_q;
   logic [NUM_BTN-1:0] pending_q, pending_d;
   logic [NUM_BTN-1:0] rpt_q, rpt_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic               valid_q, valid_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               repeat_q, repeat_d;
   logic               overrun_q, overrun_d;

   logic [NUM_BTN-1:0] set_c;
   logic [NUM_BTN-1:0] set_rpt_c;
   logic [NUM_BTN-1:0] gnt_oh_c;
   logic [ID_W-1:0]    gnt_c;
   logic               found_c;
   logic               free_c;

   // Per-button press/hold/repeat FSMs; release always returns to idle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      set_c     = '0;
      set_rpt_c = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (!btn_level[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               S_IDLE: begin
                  if (!prev_q[i]) begin
                     set_c[i]   = 1'b1;
                     cnt_d[i]   = CNT_W'(1);
                     state_d[i] = S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (cnt_q[i] == CNT_W'(HOLD_CYC)) begin
                     set_c[i]     = 1'b1;
                     set_rpt_c[i] = 1'b1;
                     cnt_d[i]     = CNT_W'(1);
                     state_d[i]   = S_RPT;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               S_RPT: begin
                  if (cnt_q[i] == CNT_W'(REPEAT_CYC)) begin
                     set_c[i]     = 1'b1;
                     set_rpt_c[i] = 1'b1;
                     cnt_d[i]     = CNT_W'(1);
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Round-robin grant: first pending index at or after rr_ptr, wrapping.
   always_comb begin
      logic [IDX_W-1:0] idx_w;
      logic [ID_W-1:0]  idx;
      free_c   = !valid_q || evt_ready;
      found_c  = 1'b0;
      gnt_c    = '0;
      gnt_oh_c = '0;
      idx_w    = '0;
      idx      = '0;
      for (int unsigned off = 0; off < NUM_BTN; off++) begin
         idx_w = {1'b0, rr_ptr_q} + IDX_W'(off);
         if (idx_w >= IDX_W'(NUM_BTN)) begin
            idx_w = idx_w - IDX_W'(NUM_BTN);
         end
         idx = idx_w[ID_W-1:0];
         if (!found_c && pending_q[idx]) begin
            found_c = 1'b1;
            gnt_c   = idx;
         end
      end
      if (free_c && found_c) begin
         gnt_oh_c[gnt_c] = 1'b1;
      end
   end

   // Pending bookkeeping and output register load.
   always_comb begin
      pending_d = pending_q;
      rpt_d     = rpt_q;
      overrun_d = 1'b0;
      rr_ptr_d  = rr_ptr_q;
      valid_d   = valid_q;
      id_d      = id_q;
      repeat_d  = repeat_q;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (gnt_oh_c[i]) begin
            pending_d[i] = 1'b0;
         end
         if (set_c[i]) begin
            // A merged event keeps press semantics if either one was a press.
            if (pending_q[i] && !gnt_oh_c[i]) begin
               overrun_d = 1'b1;
               rpt_d[i]  = rpt_q[i] & set_rpt_c[i];
            end else begin
               rpt_d[i] = set_rpt_c[i];
            end
            pending_d[i] = 1'b1;
         end
      end
      if (free_c) begin
         if (found_c) begin
            valid_d  = 1'b1;
            id_d     = gnt_c;
            repeat_d = rpt_q[gnt_c];
            rr_ptr_d = (gnt_c == ID_W'(NUM_BTN - 1)) ? '0 : gnt_c + ID_W'(1);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= btn_level;
      if (reset) begin
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         pending_q <= '0;
         rpt_q     <= '0;
         rr_ptr_q  <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         repeat_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         rpt_q     <= rpt_d;
         rr_ptr_q  <= rr_ptr_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         repeat_q  <= repeat_d;
         overrun_q <= overrun_d;
      end
   end

   assign evt_valid  = valid_q;
   assign evt_id     = id_q;
   assign evt_repeat = repeat_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed vector bench for button_event_scheduler (HOLD_CYC=20, REPEAT_CYC=10).
module tb_button_event_scheduler;

   logic       clk;
   logic       reset;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic       evt_repeat;
   logic       overrun;

   int n_vec;
   int n_bad;

   typedef struct {
      logic [3:0] btn;
      logic       rdy;
      logic       rst;
      logic       ev;
      logic [1:0] id;
      logic       rpt;
      logic       ovr;
      int         tst;
   } vec_t;

   vec_t tbl[$];

   button_event_scheduler #(
      .NUM_BTN   (4),
      .CLK_FREQ  (10_000),
      .HOLD_MS   (2),
      .REPEAT_MS (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_level  (btn_level),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_repeat (evt_repeat),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [3:0] b, input logic rdy, input logic rst, input logic ev,
                      input logic [1:0] id, input logic rpt, input logic ovr, input int tst);
      vec_t v;
      v.btn = b; v.rdy = rdy; v.rst = rst; v.ev = ev;
      v.id = id; v.rpt = rpt; v.ovr = ovr; v.tst = tst;
      tbl.push_back(v);
   endtask

   // Drive inputs for one edge, then check the registered outputs after it.
   // id/repeat hold their last value while idle, so they are checked only
   // when an event is expected or right after reset.
   task automatic step(input logic [3:0] b, input logic rdy, input logic rst, input logic ev,
                       input logic [1:0] id, input logic rpt, input logic ovr, input int tst);
      logic ok;
      @(negedge clk);
      btn_level = b;
      evt_ready = rdy;
      reset     = rst;
      @(posedge clk);
      #1;
      if (ev || rst) begin
         ok = ({evt_valid, evt_id, evt_repeat, overrun} === {ev, id, rpt, ovr});
      end else begin
         ok = (evt_valid === ev) && (overrun === ovr);
      end
      if (!ok) begin
         n_bad++;
         $display("FAIL test%0d vec%0d: got valid=%b id=%0d rpt=%b ovr=%b, want valid=%b id=%0d rpt=%b ovr=%b",
                  tst, n_vec, evt_valid, evt_id, evt_repeat, overrun, ev, id, rpt, ovr);
      end
      n_vec++;
   endtask

   initial begin
      logic [3:0] b;
      logic       ev;
      n_vec     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      btn_level = 4'b0000;
      evt_ready = 1'b1;

      // reset state
      add(4'b0000, 1, 1, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 1, 0, 0, 0, 0, 0);
      // simultaneous presses, round-robin order from rr_ptr=0, then rr_ptr=2
      add(4'b1101, 1, 0, 0, 0, 0, 0, 4);
      add(4'b1101, 1, 0, 1, 0, 0, 0, 4);
      add(4'b1101, 1, 0, 1, 2, 0, 0, 4);
      add(4'b1101, 1, 0, 1, 3, 0, 0, 4);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 4);
      add(4'b0011, 1, 0, 0, 0, 0, 0, 4);
      add(4'b0011, 1, 0, 1, 0, 0, 0, 4);
      add(4'b0011, 1, 0, 1, 1, 0, 0, 4);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 4);
      add(4'b0110, 1, 0, 0, 0, 0, 0, 4);
      add(4'b0110, 1, 0, 1, 2, 0, 0, 4);
      add(4'b0110, 1, 0, 1, 1, 0, 0, 4);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 4);
      // short press of btn0
      add(4'b0001, 1, 0, 0, 0, 0, 0, 1);
      add(4'b0001, 1, 0, 1, 0, 0, 0, 1);
      add(4'b0001, 1, 0, 0, 0, 0, 0, 1);
      add(4'b0001, 1, 0, 0, 0, 0, 0, 1);
      add(4'b0001, 1, 0, 0, 0, 0, 0, 1);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 1);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 1);
      // back-pressure, btn2 re-press merges with an overrun pulse
      add(4'b0001, 0, 0, 0, 0, 0, 0, 5);
      add(4'b0001, 0, 0, 1, 0, 0, 0, 5);
      add(4'b0101, 0, 0, 1, 0, 0, 0, 5);
      add(4'b0001, 0, 0, 1, 0, 0, 0, 5);
      add(4'b0101, 0, 0, 1, 0, 0, 1, 5);
      add(4'b0000, 0, 0, 1, 0, 0, 0, 5);
      add(4'b0000, 1, 0, 1, 2, 0, 0, 5);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 5);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 5);
      // reset with an event in flight and btn3 held
      add(4'b1000, 0, 0, 0, 0, 0, 0, 6);
      add(4'b1000, 0, 0, 1, 3, 0, 0, 6);
      add(4'b1000, 0, 1, 0, 0, 0, 0, 6);
      add(4'b1000, 1, 0, 0, 0, 0, 0, 6);
      add(4'b1000, 1, 0, 0, 0, 0, 0, 6);
      add(4'b1000, 1, 0, 0, 0, 0, 0, 6);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 6);
      add(4'b1000, 1, 0, 0, 0, 0, 0, 6);
      add(4'b1000, 1, 0, 1, 3, 0, 0, 6);
      add(4'b0000, 1, 0, 0, 0, 0, 0, 6);

      foreach (tbl[k]) begin
         step(tbl[k].btn, tbl[k].rdy, tbl[k].rst, tbl[k].ev,
              tbl[k].id, tbl[k].rpt, tbl[k].ovr, tbl[k].tst);
      end

      // btn1 held 40 edges: press at j=0, repeats set at j=20 and j=30
      for (int j = 0; j < 45; j++) begin
         b  = (j < 40) ? 4'b0010 : 4'b0000;
         ev = (j == 1) || (j == 21) || (j == 31);
         step(b, 1'b1, 1'b0, ev, 2'd1, (j != 1), 1'b0, 2);
      end

      // btn1 released one edge before its first repeat would fire
      for (int j = 0; j < 26; j++) begin
         b  = (j < 19) ? 4'b0010 : 4'b0000;
         ev = (j == 1);
         step(b, 1'b1, 1'b0, ev, 2'd1, 1'b0, 1'b0, 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
